// File: rtl/kart_scene_renderer.sv
// kart_scene_renderer
//   Renders a rotated, camera-centred top-down track with NUM_KARTS world-space
//   kart sprites. Texture and sprite colours come from external memories that
//   have a fixed read latency of MEM_LAT cycles. The final pixel is composited
//   by kart priority, and sprite texels equal to KEY_COLOR are transparent.
//   Pixel latency from hcount_in/vcount_in to pixel_out is 4 + MEM_LAT.
//
// Ports
//   clk_in, rst_in            pixel clock, synchronous active-high reset
//   hcount_in, vcount_in      screen position of the incoming pixel
//   cam_x_in, cam_y_in        camera world position (latched once per frame)
//   cos_in, sin_in            signed Q1.FRAC direction (latched once per frame)
//   kart_x_in, kart_y_in      packed kart world positions, kart i at [11i+10:11i]
//   world_x_out, world_y_out  texture lookup address
//   tex_color_in              track colour, MEM_LAT cycles after world_*_out
//   sprite_addr_out           {kart, v, u} sprite texel address
//   sprite_color_in           sprite colour, MEM_LAT cycles after sprite_addr_out
//   pixel_out                 composited RGB444
//   kart_id_out               {visible, kart index}
//   hcount_out, vcount_out    hcount_in/vcount_in delayed to line up with pixel_out
module kart_scene_renderer #(
   parameter int          NUM_KARTS  = 4,
   parameter int          CENTER_X   = 512,
   parameter int          CENTER_Y   = 384,
   parameter int          V_LATCH    = 768,
   parameter int          FRAC       = 9,
   parameter int          KART_SIZE  = 128,
   parameter int          SPRITE_DIM = 32,
   parameter int          MEM_LAT    = 2,
   parameter logic [11:0] KEY_COLOR  = 12'h406,
   parameter logic [11:0] OOB_COLOR  = 12'h000
) (
   input  logic                                                  clk_in,
   input  logic                                                  rst_in,
   input  logic [10:0]                                           hcount_in,
   input  logic [9:0]                                            vcount_in,
   input  logic [10:0]                                           cam_x_in,
   input  logic [10:0]                                           cam_y_in,
   input  logic [10:0]                                           cos_in,
   input  logic [10:0]                                           sin_in,
   input  logic [NUM_KARTS*11-1:0]                               kart_x_in,
   input  logic [NUM_KARTS*11-1:0]                               kart_y_in,
   output logic [10:0]                                           world_x_out,
   output logic [10:0]                                           world_y_out,
   input  logic [11:0]                                           tex_color_in,
   output logic [$clog2(NUM_KARTS)+2*$clog2(SPRITE_DIM)-1:0]     sprite_addr_out,
   input  logic [11:0]                                           sprite_color_in,
   output logic [11:0]                                           pixel_out,
   output logic [$clog2(NUM_KARTS):0]                            kart_id_out,
   output logic [10:0]                                           hcount_out,
   output logic [9:0]                                            vcount_out
);

   localparam int KID_W   = $clog2(NUM_KARTS);
   localparam int SPR_W   = $clog2(SPRITE_DIM);
   localparam int SHIFT   = $clog2(KART_SIZE / SPRITE_DIM);
   localparam int HALF    = KART_SIZE / 2;
   localparam int LATENCY = 4 + MEM_LAT;
   localparam int FLAG_W  = KID_W + 3;
   localparam logic signed [14:0] KS_S = 15'(KART_SIZE);

   // ---------------------------------------------------------------
   // Frame shadow registers: everything downstream uses only these, so
   // mid-frame input changes cannot tear the picture.
   // ---------------------------------------------------------------
   logic                       frame_latch;
   logic [10:0]                cam_x_sh, cam_y_sh;
   logic signed [10:0]         cos_sh, sin_sh;
   logic [NUM_KARTS*11-1:0]    kart_x_sh, kart_y_sh;

   assign frame_latch = (hcount_in == 11'd0) && (vcount_in == 10'(V_LATCH));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cam_x_sh  <= '0;
         cam_y_sh  <= '0;
         cos_sh    <= '0;
         sin_sh    <= '0;
         kart_x_sh <= '0;
         kart_y_sh <= '0;
      end else if (frame_latch) begin
         cam_x_sh  <= cam_x_in;
         cam_y_sh  <= cam_y_in;
         cos_sh    <= cos_in;
         sin_sh    <= sin_in;
         kart_x_sh <= kart_x_in;
         kart_y_sh <= kart_y_in;
      end
   end

   // ---------------------------------------------------------------
   // S0: screen offset from the camera centre.
   // A valid bit travels with each pixel so that pixels caught in flight by
   // a reset are never presented.
   // ---------------------------------------------------------------
   logic signed [11:0] dx_s0, dy_s0;
   logic               vld_s0;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         dx_s0  <= '0;
         dy_s0  <= '0;
         vld_s0 <= 1'b0;
      end else begin
         dx_s0  <= {1'b0, hcount_in} - 12'(CENTER_X);
         dy_s0  <= {2'b00, vcount_in} - 12'(CENTER_Y);
         vld_s0 <= 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // S1: rotation products.
   // ---------------------------------------------------------------
   logic signed [22:0] dx_ext, dy_ext, cos_ext, sin_ext;
   logic signed [22:0] p_xc, p_ys, p_xs, p_yc;
   logic               vld_s1;

   assign dx_ext  = {{11{dx_s0[11]}}, dx_s0};
   assign dy_ext  = {{11{dy_s0[11]}}, dy_s0};
   assign cos_ext = {{12{cos_sh[10]}}, cos_sh};
   assign sin_ext = {{12{sin_sh[10]}}, sin_sh};

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         p_xc   <= '0;
         p_ys   <= '0;
         p_xs   <= '0;
         p_yc   <= '0;
         vld_s1 <= 1'b0;
      end else begin
         p_xc   <= dx_ext * cos_ext;
         p_ys   <= dy_ext * sin_ext;
         p_xs   <= dx_ext * sin_ext;
         p_yc   <= dy_ext * cos_ext;
         vld_s1 <= vld_s0;
      end
   end

   // ---------------------------------------------------------------
   // S2: world coordinate. >>> on a signed value floors, so a pixel just
   // left of the centre lands on the texel to the left, not on the centre.
   // ---------------------------------------------------------------
   logic signed [24:0] sum_x, sum_y;
   logic [13:0]        rot_x, rot_y;
   logic signed [13:0] wx_s2, wy_s2;
   logic               vld_s2;

   assign sum_x = {{2{p_xc[22]}}, p_xc} - {{2{p_ys[22]}}, p_ys};
   assign sum_y = {{2{p_xs[22]}}, p_xs} + {{2{p_yc[22]}}, p_yc};
   assign rot_x = 14'(sum_x >>> FRAC);
   assign rot_y = 14'(sum_y >>> FRAC);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wx_s2  <= '0;
         wy_s2  <= '0;
         vld_s2 <= 1'b0;
      end else begin
         wx_s2  <= {3'b000, cam_x_sh} + rot_x;
         wy_s2  <= {3'b000, cam_y_sh} + rot_y;
         vld_s2 <= vld_s1;
      end
   end

   // ---------------------------------------------------------------
   // S3: memory addresses and hit test (combinational from S2 so the
   // external memories see the address one stage earlier).
   // ---------------------------------------------------------------
   logic                 oob_s3;
   logic [NUM_KARTS-1:0] hit_vec;
   logic [2*SPR_W-1:0]   uv_vec [NUM_KARTS];
   logic                 sel_hit;
   logic [KID_W-1:0]     sel_idx;
   logic [2*SPR_W-1:0]   sel_uv;

   assign world_x_out = wx_s2[10:0];
   assign world_y_out = wy_s2[10:0];

   // Anything above bit 10 set means negative or beyond 2047.
   assign oob_s3 = (wx_s2[13:11] != 3'b000) || (wy_s2[13:11] != 3'b000);

   for (genvar k = 0; k < NUM_KARTS; k++) begin : g_kart
      logic signed [14:0] u, v;

      // Signed 15-bit offsets: a kart straddling the world edge sees negative
      // world coordinates as negative, never as wrapped texture addresses.
      assign u = {wx_s2[13], wx_s2} - {4'b0000, kart_x_sh[11*k +: 11]} + 15'(HALF);
      assign v = {wy_s2[13], wy_s2} - {4'b0000, kart_y_sh[11*k +: 11]} + 15'(HALF);

      assign hit_vec[k] = (u >= 15'sd0) && (u < KS_S) && (v >= 15'sd0) && (v < KS_S);
      assign uv_vec[k]  = {v[SHIFT +: SPR_W], u[SHIFT +: SPR_W]};
   end

   // Walk from the highest index down so the lowest-index hit ends up selected.
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      sel_uv  = '0;
      for (int i = NUM_KARTS - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            sel_hit = 1'b1;
            sel_idx = KID_W'(i);
            sel_uv  = uv_vec[i];
         end
      end
      if (!vld_s2) begin
         sel_hit = 1'b0;
      end
   end

   assign sprite_addr_out = sel_hit ? {sel_idx, sel_uv} : '0;

   // ---------------------------------------------------------------
   // Flag delay line: align hit/oob/index with the returned colours.
   // ---------------------------------------------------------------
   logic [FLAG_W-1:0] flag_d [MEM_LAT];
   logic              fl_vld, fl_oob, fl_hit;
   logic [KID_W-1:0]  fl_idx;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            flag_d[i] <= '0;
         end
      end else begin
         flag_d[0] <= {vld_s2, oob_s3, sel_hit, sel_idx};
         for (int i = 1; i < MEM_LAT; i++) begin
            flag_d[i] <= flag_d[i-1];
         end
      end
   end

   assign {fl_vld, fl_oob, fl_hit, fl_idx} = flag_d[MEM_LAT-1];

   // ---------------------------------------------------------------
   // Final compositing. A keyed texel falls straight through to the track;
   // lower-priority karts underneath it are deliberately not consulted.
   // ---------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pixel_out   <= '0;
         kart_id_out <= '0;
      end else if (!fl_vld) begin
         pixel_out   <= '0;
         kart_id_out <= '0;
      end else if (fl_hit && (sprite_color_in != KEY_COLOR)) begin
         pixel_out   <= sprite_color_in;
         kart_id_out <= {1'b1, fl_idx};
      end else if (fl_oob) begin
         pixel_out   <= OOB_COLOR;
         kart_id_out <= '0;
      end else begin
         pixel_out   <= tex_color_in;
         kart_id_out <= '0;
      end
   end

   // ---------------------------------------------------------------
   // Screen position delay, runs every cycle including blanking.
   // ---------------------------------------------------------------
   logic [20:0] pos_d [LATENCY];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < LATENCY; i++) begin
            pos_d[i] <= '0;
         end
      end else begin
         pos_d[0] <= {hcount_in, vcount_in};
         for (int i = 1; i < LATENCY; i++) begin
            pos_d[i] <= pos_d[i-1];
         end
      end
   end

   assign {hcount_out, vcount_out} = pos_d[LATENCY-1];

endmodule

// File: tb/tb_kart_scene_renderer.sv
module tb_kart_scene_renderer;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [10:0] cam_x_in, cam_y_in, cos_in, sin_in;
   logic [43:0] kart_x_in, kart_y_in;
   logic [10:0] world_x_out, world_y_out;
   logic [11:0] tex_color_in = '0;
   logic [11:0] sprite_addr_out;
   logic [11:0] sprite_color_in = '0;
   logic [11:0] pixel_out;
   logic [2:0]  kart_id_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;

   kart_scene_renderer dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .hcount_in       (hcount_in),
      .vcount_in       (vcount_in),
      .cam_x_in        (cam_x_in),
      .cam_y_in        (cam_y_in),
      .cos_in          (cos_in),
      .sin_in          (sin_in),
      .kart_x_in       (kart_x_in),
      .kart_y_in       (kart_y_in),
      .world_x_out     (world_x_out),
      .world_y_out     (world_y_out),
      .tex_color_in    (tex_color_in),
      .sprite_addr_out (sprite_addr_out),
      .sprite_color_in (sprite_color_in),
      .pixel_out       (pixel_out),
      .kart_id_out     (kart_id_out),
      .hcount_out      (hcount_out),
      .vcount_out      (vcount_out)
   );

   always #5 clk_in = ~clk_in;

   localparam int K_WX = 0, K_WY = 1, K_SA = 2, K_PIX = 3, K_ID = 4, K_HC = 5, K_VC = 6;
   localparam logic [11:0] KEY = 12'h406;

   typedef struct {
      int due;
      int kind;
      int exp;
   } exp_t;

   exp_t        sb_q[$];
   int          errors  = 0;
   int          checks  = 0;
   int          neg_cnt = 0;
   logic [11:0] spr_val = 12'h123;

   // Track texture: neighbouring texels differ so a latency slip shows up.
   function automatic logic [11:0] tex_fn(input logic [10:0] x, input logic [10:0] y);
      return {x[3:0] ^ 4'h5, y[3:0], x[7:4]};
   endfunction

   function automatic logic [11:0] spr_fn(input logic [11:0] a);
      return (a == 12'd528) ? spr_val : 12'h0F0;
   endfunction

   // External memories, two-cycle read latency.
   logic [11:0] tex_d1 = '0, spr_d1 = '0;
   always @(posedge clk_in) begin
      tex_d1          <= tex_fn(world_x_out, world_y_out);
      tex_color_in    <= tex_d1;
      spr_d1          <= spr_fn(sprite_addr_out);
      sprite_color_in <= spr_d1;
   end

   function automatic int actual(input int kind);
      case (kind)
         K_WX:    return int'(world_x_out);
         K_WY:    return int'(world_y_out);
         K_SA:    return int'(sprite_addr_out);
         K_PIX:   return int'(pixel_out);
         K_ID:    return int'(kart_id_out);
         K_HC:    return int'(hcount_out);
         default: return int'(vcount_out);
      endcase
   endfunction

   function automatic string kname(input int kind);
      case (kind)
         K_WX:    return "world_x";
         K_WY:    return "world_y";
         K_SA:    return "sprite_addr";
         K_PIX:   return "pixel";
         K_ID:    return "kart_id";
         K_HC:    return "hcount_out";
         default: return "vcount_out";
      endcase
   endfunction

   // Monitor: compare every expectation that falls due on this sample point.
   always @(negedge clk_in) begin : monitor
      exp_t keep[$];
      int   act;
      neg_cnt++;
      keep = {};
      foreach (sb_q[i]) begin
         if (sb_q[i].due == neg_cnt) begin
            checks++;
            act = actual(sb_q[i].kind);
            if (act != sb_q[i].exp) begin
               errors++;
               $display("FAIL %s at sample %0d: actual=0x%0h expected=0x%0h",
                        kname(sb_q[i].kind), neg_cnt, act, sb_q[i].exp);
            end
         end else if (sb_q[i].due < neg_cnt) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for sample %0d was never compared",
                     kname(sb_q[i].kind), sb_q[i].due);
         end else begin
            keep.push_back(sb_q[i]);
         end
      end
      sb_q = keep;
   end

   task automatic push(input int due, input int kind, input int exp);
      exp_t e;
      e.due  = due;
      e.kind = kind;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic step(input int h, input int v, input logic r);
      @(posedge clk_in);
      #1;
      hcount_in = 11'(h);
      vcount_in = 10'(v);
      rst_in    = r;
   endtask

   // World/sprite address appear 3 edges after capture, pixel 6 edges after.
   task automatic pix(input int h, input int v, input int ewx, input int ewy,
                      input int esa, input int epix, input int eid);
      step(h, v, 1'b0);
      push(neg_cnt + 4, K_WX, ewx);
      push(neg_cnt + 4, K_WY, ewy);
      push(neg_cnt + 4, K_SA, esa);
      push(neg_cnt + 7, K_PIX, epix);
      push(neg_cnt + 7, K_ID, eid);
      push(neg_cnt + 7, K_HC, h);
      push(neg_cnt + 7, K_VC, v);
   endtask

   task automatic rst_pulse(input int h, input int v);
      step(h, v, 1'b1);
      for (int k = K_WX; k <= K_VC; k++) begin
         push(neg_cnt + 2, k, 0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step(1500, 500, 1'b0);
      end
   endtask

   task automatic latch();
      idle(8);
      step(0, 768, 1'b0);
   endtask

   function automatic logic [43:0] pack4(input int a, input int b, input int c, input int d);
      return {11'(d), 11'(c), 11'(b), 11'(a)};
   endfunction

   initial begin
      rst_in    = 1'b1;
      hcount_in = '0;
      vcount_in = '0;
      cam_x_in  = 11'd0;
      cam_y_in  = 11'd0;
      cos_in    = 11'd0;
      sin_in    = 11'd0;
      kart_x_in = '0;
      kart_y_in = '0;

      // Reset state
      rst_pulse(700, 300);
      rst_pulse(701, 300);

      // Identity transform, karts far away
      cam_x_in  = 11'd1000;
      cam_y_in  = 11'd1000;
      cos_in    = 11'd512;
      sin_in    = 11'd0;
      kart_x_in = pack4(100, 200, 300, 400);
      kart_y_in = pack4(100, 200, 300, 400);
      latch();
      pix(512, 384, 1000, 1000, 0, tex_fn(1000, 1000), 0);
      pix(600, 384, 1088, 1000, 0, tex_fn(1088, 1000), 0);
      pix(513, 384, 1001, 1000, 0, tex_fn(1001, 1000), 0);
      pix(511, 385,  999, 1001, 0, tex_fn(999, 1001), 0);

      // 90 degree rotation
      cos_in = 11'd0;
      sin_in = 11'd512;
      latch();
      pix(612, 384, 1000, 1100, 0, tex_fn(1000, 1100), 0);
      pix(512, 284, 1100, 1000, 0, tex_fn(1100, 1000), 0);

      // Half scale: arithmetic shift must floor negative offsets
      cos_in = 11'd256;
      sin_in = 11'd0;
      latch();
      pix(511, 384,  999, 1000, 0, tex_fn(999, 1000), 0);
      pix(513, 384, 1000, 1000, 0, tex_fn(1000, 1000), 0);
      pix(512, 383, 1000,  999, 0, tex_fn(1000, 999), 0);

      // Priority and footprint edges
      cos_in    = 11'd512;
      sin_in    = 11'd0;
      kart_x_in = pack4(1000, 1100, 1000, 100);
      kart_y_in = pack4(1000, 1000, 1000, 100);
      spr_val   = 12'hF00;
      latch();
      pix(512, 384, 1000, 1000,  528, 12'hF00, 4);
      pix(575, 384, 1063, 1000,  543, 12'h0F0, 4);
      pix(576, 384, 1064, 1000, 1543, 12'h0F0, 5);
      pix(612, 384, 1100, 1000, 1552, 12'h0F0, 5);
      pix(512, 447, 1000, 1063, 1008, 12'h0F0, 4);
      pix(512, 448, 1000, 1064,    0, tex_fn(1000, 1064), 0);
      idle(8);
      spr_val = KEY;
      pix(512, 384, 1000, 1000, 528, tex_fn(1000, 1000), 0);
      idle(8);

      // Out of bounds, kart straddling the world edge
      cam_x_in  = 11'd10;
      cam_y_in  = 11'd10;
      kart_x_in = pack4(1000, 1100, 1000, 0);
      kart_y_in = pack4(1000, 1000, 1000, 0);
      latch();
      pix(0,     0, 1546, 1674,    0, 0, 0);
      pix(482, 379, 2028,    5, 3627, 12'h0F0, 7);
      pix(437, 379, 1983,    5,    0, 0, 0);
      pix(600, 400,   98,   26,    0, tex_fn(98, 26), 0);

      // Frame latch: mid-frame camera change waits for the latch
      cam_x_in = 11'd1500;
      cam_y_in = 11'd1500;
      latch();
      pix(512, 200, 1500, 1316, 0, tex_fn(1500, 1316), 0);
      cam_x_in = 11'd1600;
      cam_y_in = 11'd1400;
      pix(512, 201, 1500, 1317, 0, tex_fn(1500, 1317), 0);
      latch();
      pix(512, 201, 1600, 1217, 0, tex_fn(1600, 1217), 0);
      idle(8);

      // Mid-line reset: in-flight pixels vanish, shadows return to zero
      spr_val = 12'h123;
      step(700, 300, 1'b0);
      rst_pulse(701, 300);
      push(neg_cnt + 3, K_PIX, 0);
      push(neg_cnt + 5, K_PIX, 0);
      push(neg_cnt + 7, K_PIX, 0);
      push(neg_cnt + 7, K_HC, 0);
      pix(512, 384, 0, 0, 528, 12'h123, 4);
      pix(900, 100, 0, 0, 528, 12'h123, 4);

      for (int i = 0; i < 30 && sb_q.size() > 0; i++) begin
         step(1500, 500, 1'b0);
      end
      foreach (sb_q[i]) begin
         checks++;
         errors++;
         $display("FAIL %s: expectation for sample %0d still pending at end",
                  kname(sb_q[i].kind), sb_q[i].due);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/kart_scene_renderer.md
Name: kart_scene_renderer

Overview:
- Parametrised successor to the single-opponent racer view. Renders a rotated, camera-centred top-down track with NUM_KARTS world-space kart sprites, composited by fixed priority with a transparency key.
- Sits between the video timing generator and the HDMI/VGA pixel path.
- Texture and sprite colour lookups are external fixed-latency memories (tile/palette subsystem, shared kart sprite ROM). This block owns the coordinate transform, hit testing, address generation, compositing and timing alignment.
- Camera, rotation and kart positions are latched once per frame, so no tearing occurs.

Parameters:
- NUM_KARTS, 4, number of karts. Kart 0 is the player and has the highest priority.
- CENTER_X, 512, screen hcount mapped to the camera position.
- CENTER_Y, 384, screen vcount mapped to the camera position.
- V_LATCH, 768, vcount at which frame state is latched (first blanking line).
- FRAC, 9, fractional bits of cos/sin (512 = 1.0).
- KART_SIZE, 128, kart footprint in world units; power of two.
- SPRITE_DIM, 32, sprite texels per side; power of two, ≤ KART_SIZE.
- MEM_LAT, 2, fixed read latency of both external memories, in cycles.
- KEY_COLOR, 12'h406, transparent sprite colour.
- OOB_COLOR, 12'h000, colour for world coordinates outside 0..2047.

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  synchronous active-high reset
- hcount_in  in  11  pixel column
- vcount_in  in  10  pixel row
- cam_x_in  in  11  camera world x
- cam_y_in  in  11  camera world y
- cos_in  in  11  signed cos(direction), Q1.FRAC
- sin_in  in  11  signed sin(direction), Q1.FRAC
- kart_x_in  in  NUM_KARTS*11  packed kart world x (kart i at [11i+10:11i])
- kart_y_in  in  NUM_KARTS*11  packed kart world y
- world_x_out  out  11  texture lookup x
- world_y_out  out  11  texture lookup y
- tex_color_in  in  12  track colour, MEM_LAT cycles after world_*_out
- sprite_addr_out  out  clog2(NUM_KARTS)+2*clog2(SPRITE_DIM)  {kart, v, u}
- sprite_color_in  in  12  sprite colour, MEM_LAT cycles after sprite_addr_out
- pixel_out  out  12  composited RGB444
- kart_id_out  out  clog2(NUM_KARTS)+1  MSB = kart visible; LSBs = drawn kart index
- hcount_out  out  11  hcount_in delayed by LATENCY
- vcount_out  out  10  vcount_in delayed by LATENCY

Behaviour:
- Reset (synchronous, rst_in high at clk edge):
  - All outputs, pipeline registers and latched frame state clear to 0.
  - Reset asserted mid-frame takes effect on the next edge; no partial pixels are output.
- Frame latch:
  - Fires when hcount_in==0 && vcount_in==V_LATCH.
  - Captures cam_*, cos/sin and all kart_* into shadow registers.
  - Between latches, all arithmetic uses only the shadow values. Input changes mid-frame have no visible effect.
- Pipeline:
  - LATENCY = 4 + MEM_LAT. Fully pipelined, one pixel per clock, no stalls.
  - S0: dx = hcount_in − CENTER_X, dy = vcount_in − CENTER_Y, both signed 12-bit, registered.
  - S1: four signed products (23-bit), registered.
  - S2: wx = cam_x + ((dx·cos − dy·sin) >>> FRAC); wy = cam_y + ((dx·sin + dy·cos) >>> FRAC). Shift is arithmetic (floor, not truncate-toward-zero). Result is signed 14-bit, registered.
  - S3 outputs world_x_out/world_y_out = wx[10:0], wy[10:0]. oob = wx or wy outside 0..2047.
  - S3 per-kart hit test, for each kart i:
    - u = wx − kart_x[i] + KART_SIZE/2 and v = wy − kart_y[i] + KART_SIZE/2, both signed.
    - Hit iff 0 ≤ u < KART_SIZE and 0 ≤ v < KART_SIZE.
    - The lowest-index hit wins. sprite_addr_out = {i, v>>S, u>>S}, with S = log2(KART_SIZE/SPRITE_DIM).
    - No hit: sprite_addr_out = 0 and the visible flag is 0.
  - Flags (oob, hit, index) are delayed MEM_LAT cycles to align with the returned colours.
  - Final stage, registered priority:
    1. If hit and sprite_color_in ≠ KEY_COLOR: pixel_out = sprite colour; kart_id_out = {1, idx}.
    2. Else if oob: pixel_out = OOB_COLOR.
    3. Else: pixel_out = tex_color_in; kart_id_out MSB = 0.
  - A keyed sprite texel shows the track beneath it. Lower-priority karts beneath a keyed texel are not drawn.
- Boundaries:
  - Karts straddling the world edge test correctly: signed compare, no wrap.
  - Negative world coordinates never alias into valid texture.
  - hcount_out/vcount_out track every cycle, including during blanking.

Test Plan:
- Identity, in bounds: cos=512, sin=0, cam=(1000,1000), frame latched, no karts nearby, pixel (512,384) → world_out=(1000,1000); (600,384) → (1088,1000); pixel_out = tex_color_in sampled MEM_LAT later; total latency exactly 4+MEM_LAT.
- 90° rotation: cos=0, sin=512, cam=(1000,1000), pixel (612,384) → world (1000,1100); pixel (512,284) → (1100,1000).
- Priority: karts 0 and 2 both at (1000,1000), pixel (512,384) → sprite_addr_out = {0,16,16}; with sprite colour 12'hF00 returned → pixel_out=12'hF00, kart_id_out={1,0}. With colour KEY_COLOR → track colour, MSB 0.
- OOB: cam=(10,10), cos=512, pixel (0,0) → wx=−502 → pixel_out=OOB_COLOR regardless of tex_color_in.
- Frame latch: change cam_x_in mid-frame at vcount 200 → world_out unchanged until after the hcount 0 / vcount 768 latch, then shifts by the delta.
- Reset: assert rst_in for 1 cycle mid-line → next cycle all outputs 0; shadow registers 0, so the next pixels use cos=sin=0 and cam=(0,0) until the next latch.
